// File: rtl/ram_io_timer_pkg.sv
// Shared definitions for the bus RAM / I/O timer block: command codes,
// timer modes, I/O register offsets and STATUS bit positions.
package ram8156_pkg;

    // CMD[7:6] encodings
    typedef enum logic [1:0] {
        CMD_NOP     = 2'b00,
        CMD_STOP    = 2'b01,
        CMD_STOP_TC = 2'b10,
        CMD_START   = 2'b11
    } cmd_e;

    // THI[7:6]: bit0 = continuous, bit1 = pulse output
    typedef enum logic [1:0] {
        MODE_SQ_SINGLE    = 2'b00,
        MODE_SQ_CONT      = 2'b01,
        MODE_PULSE_SINGLE = 2'b10,
        MODE_PULSE_CONT   = 2'b11
    } tmode_e;

    localparam logic [2:0] REG_CMD = 3'd0;
    localparam logic [2:0] REG_TLO = 3'd4;
    localparam logic [2:0] REG_THI = 3'd5;

    localparam int ST_TC_BIT  = 6;
    localparam int ST_RUN_BIT = 7;

    function automatic logic mode_is_cont(input tmode_e m);
        return m[0];
    endfunction

    function automatic logic mode_is_pulse(input tmode_e m);
        return m[1];
    endfunction

endpackage

// File: rtl/rio_timer.sv
// Programmable down-counter: run/stop control, stop-after-TC, TC flag and
// a registered output waveform (square or single-cycle low pulse).
module rio_timer
    import ram8156_pkg::*;
#(
    parameter int TIMER_W = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce_i,
    input  logic               cmd_we_i,
    input  cmd_e               cmd_i,
    input  logic [TIMER_W-1:0] len_i,
    input  tmode_e             mode_i,
    input  logic               tc_clr_i,
    output logic               running_o,
    output logic               tc_flag_o,
    output logic               timer_out_o
);

    logic [TIMER_W-1:0] cnt_q, cnt_d;
    logic [TIMER_W-1:0] len_q, len_d;
    tmode_e             mode_q, mode_d;
    logic               run_q, run_d;
    logic               stop_tc_q, stop_tc_d;
    logic               tc_flag_q, tc_flag_d;
    logic               out_q, out_d;
    logic               tc;
    logic [TIMER_W-1:0] len_eff;

    // Lengths below 2 cannot produce a meaningful waveform, so they run as 2
    assign len_eff = (len_i < TIMER_W'(2)) ? TIMER_W'(2) : len_i;

    // Next-state: a command write takes the cycle; otherwise count when enabled
    always_comb begin
        cnt_d     = cnt_q;
        len_d     = len_q;
        mode_d    = mode_q;
        run_d     = run_q;
        stop_tc_d = stop_tc_q;
        tc        = 1'b0;
        if (cmd_we_i) begin
            case (cmd_i)
                CMD_START: begin
                    cnt_d     = len_eff;
                    len_d     = len_eff;
                    mode_d    = mode_i;
                    run_d     = 1'b1;
                    stop_tc_d = 1'b0;
                end
                CMD_STOP: begin
                    run_d     = 1'b0;
                    stop_tc_d = 1'b0;
                end
                CMD_STOP_TC: stop_tc_d = run_q;
                default: ;
            endcase
        end else if (run_q && ce_i) begin
            if (cnt_q == TIMER_W'(1)) begin
                tc = 1'b1;
                if (mode_is_cont(mode_q) && !stop_tc_q) begin
                    cnt_d = len_q;
                end else begin
                    run_d     = 1'b0;
                    stop_tc_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q - TIMER_W'(1);
            end
        end
        // A TC in the same cycle as a STATUS-read clear keeps the flag set
        tc_flag_d = tc ? 1'b1 : (tc_clr_i ? 1'b0 : tc_flag_q);
        // Output is computed from next-state so it lines up with cnt_q
        if (!run_d)
            out_d = 1'b1;
        else if (mode_is_pulse(mode_d))
            out_d = (cnt_d != TIMER_W'(1));
        else
            out_d = (cnt_d > (len_d >> 1));
    end

    // Timer state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            len_q     <= '0;
            mode_q    <= MODE_SQ_SINGLE;
            run_q     <= 1'b0;
            stop_tc_q <= 1'b0;
            tc_flag_q <= 1'b0;
            out_q     <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            mode_q    <= mode_d;
            run_q     <= run_d;
            stop_tc_q <= stop_tc_d;
            tc_flag_q <= tc_flag_d;
            out_q     <= out_d;
        end
    end

    assign running_o   = run_q;
    assign tc_flag_o   = tc_flag_q;
    assign timer_out_o = out_q;

endmodule

// File: rtl/ram_io_timer.sv
// Multiplexed-bus static RAM with ALE address latch, I/O-mapped
// command/status and timer length registers, and the timer sub-block.
module ram_io_timer
    import ram8156_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 8,
    parameter int TIMER_W      = 14,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [DATA_W-1:0] ad,
    input  logic              ale,
    input  logic              cs_n,
    input  logic              iom,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic              timer_ce,
    output logic              timer_out
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [ADDR_W-1:0] a_q;
    logic              sel_q;
    logic              io_q;
    logic [DATA_W-1:0] rdata_q;
    logic [7:0]        tlo_q;
    logic [7:0]        thi_q;
    logic              st_rd_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              bus_rd, bus_wr;
    logic              mem_we, reg_we, cmd_we;
    logic              st_rd, tc_clr;
    logic [2:0]        reg_off;
    logic [7:0]        reg_rdata;
    logic              running, tc_flag;

    // Strobes are ignored during the address phase; write wins over read
    assign bus_rd  = sel_q & ~rd_n & wr_n & ~ale;
    assign bus_wr  = sel_q & ~wr_n & ~ale;
    assign mem_we  = bus_wr & ~io_q;
    assign reg_we  = bus_wr & io_q;
    assign reg_off = a_q[2:0];
    assign cmd_we  = reg_we & (reg_off == REG_CMD);
    assign st_rd   = bus_rd & io_q & (reg_off == REG_CMD);
    // Flag clears on the edge where a STATUS read has just ended
    assign tc_clr  = st_rd_q & rd_n;

    assign ad = bus_rd ? rdata_q : {DATA_W{1'bz}};

    // Address phase latch
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            sel_q <= 1'b0;
            io_q  <= 1'b0;
        end else if (ale) begin
            a_q   <= ad[ADDR_W-1:0];
            sel_q <= ~cs_n;
            io_q  <= iom;
        end
    end

    // RAM array, optionally cleared by reset
    if (CLEAR_ON_RST != 0) begin : g_mem_clr
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            end else if (mem_we) begin
                mem[a_q] <= ad;
            end
        end
    end else begin : g_mem_keep
        always_ff @(posedge clk) begin
            if (!rst && mem_we) mem[a_q] <= ad;
        end
    end

    // Timer length/mode registers
    always_ff @(posedge clk) begin
        if (rst) begin
            tlo_q <= '0;
            thi_q <= '0;
        end else if (reg_we) begin
            if (reg_off == REG_TLO) tlo_q <= ad[7:0];
            if (reg_off == REG_THI) thi_q <= ad[7:0];
        end
    end

    // I/O register read mux; unmapped offsets read 0
    always_comb begin
        reg_rdata = '0;
        case (reg_off)
            REG_CMD: begin
                reg_rdata[ST_RUN_BIT] = running;
                reg_rdata[ST_TC_BIT]  = tc_flag;
            end
            REG_TLO: reg_rdata = tlo_q;
            REG_THI: reg_rdata = thi_q;
            default: ;
        endcase
    end

    // Read data pipeline register and STATUS-read tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            st_rd_q <= 1'b0;
        end else begin
            rdata_q <= io_q ? DATA_W'(reg_rdata) : mem[a_q];
            st_rd_q <= st_rd;
        end
    end

    rio_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .ce_i        (timer_ce),
        .cmd_we_i    (cmd_we),
        .cmd_i       (cmd_e'(ad[7:6])),
        .len_i       (TIMER_W'({thi_q[5:0], tlo_q})),
        .mode_i      (tmode_e'(thi_q[7:6])),
        .tc_clr_i    (tc_clr),
        .running_o   (running),
        .tc_flag_o   (tc_flag),
        .timer_out_o (timer_out)
    );

endmodule

// File: tb/tb_ram_io_timer.sv
// Directed bench for ram_io_timer: RAM access over the muxed bus, chip
// select and strobe conflicts, timer modes, status flag and reset.
module tb_ram_io_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ale = 1'b0;
    logic       cs_n = 1'b1;
    logic       iom = 1'b0;
    logic       rd_n = 1'b1;
    logic       wr_n = 1'b1;
    logic       timer_ce = 1'b0;
    logic       timer_out;
    logic [7:0] drv = 8'h00;
    logic       drv_en = 1'b0;
    wire  [7:0] ad;

    int vectors = 0;
    int miscompares = 0;

    // Undriven bus floats high so "not driven" reads as 0xFF
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (ad[g]);
    end
    assign ad = drv_en ? drv : 8'bz;

    always #5 clk = ~clk;

    ram_io_timer #(
        .DATA_W(8), .ADDR_W(8), .TIMER_W(14), .CLEAR_ON_RST(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ad        (ad),
        .ale       (ale),
        .cs_n      (cs_n),
        .iom       (iom),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .timer_ce  (timer_ce),
        .timer_out (timer_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_addr(input logic [7:0] a, input logic io, input logic cs);
        ale = 1'b1; cs_n = ~cs; iom = io; drv = a; drv_en = 1'b1;
        tick();
        ale = 1'b0; drv_en = 1'b0;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic io, input logic [7:0] d);
        bus_addr(a, io, 1'b1);
        drv = d; drv_en = 1'b1; wr_n = 1'b0;
        tick();
        wr_n = 1'b1; drv_en = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, input logic io, input logic cs, output logic [7:0] got);
        bus_addr(a, io, cs);
        rd_n = 1'b0;
        tick();
        got = ad;
        rd_n = 1'b1;
    endtask

    initial begin
        logic [7:0] got;
        int lows;

        // Reset state
        tick(); tick();
        check("rst_timer_out", {15'd0, timer_out}, 16'h0001);
        check("rst_bus_float", {8'h00, ad}, 16'h00FF);
        rst = 1'b0;
        bus_read(8'h00, 1'b1, 1'b1, got); check("rst_status", {8'h00, got}, 16'h0000);
        bus_read(8'h04, 1'b1, 1'b1, got); check("rst_tlo", {8'h00, got}, 16'h0000);
        bus_read(8'h3C, 1'b0, 1'b1, got); check("rst_mem3c", {8'h00, got}, 16'h0000);

        // Basic RAM write/read and deselected read
        bus_write(8'h3C, 1'b0, 8'hA5);
        bus_read(8'h3C, 1'b0, 1'b1, got); check("mem3c_a5", {8'h00, got}, 16'h00A5);
        bus_read(8'h3C, 1'b0, 1'b0, got); check("cs_off_float", {8'h00, got}, 16'h00FF);

        // Address extremes
        bus_write(8'h00, 1'b0, 8'h10);
        bus_write(8'hFF, 1'b0, 8'h20);
        bus_read(8'hFF, 1'b0, 1'b1, got); check("memff", {8'h00, got}, 16'h0020);
        bus_read(8'h00, 1'b0, 1'b1, got); check("mem00", {8'h00, got}, 16'h0010);

        // rd_n and wr_n both low: no drive, write happens
        bus_addr(8'h55, 1'b0, 1'b1);
        rd_n = 1'b0; wr_n = 1'b0;
        #1 check("rdwr_no_drive", {8'h00, ad}, 16'h00FF);
        drv = 8'h77; drv_en = 1'b1;
        tick();
        drv_en = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
        bus_read(8'h55, 1'b0, 1'b1, got); check("rdwr_written", {8'h00, got}, 16'h0077);

        // Continuous square wave, L=6
        timer_ce = 1'b1;
        bus_write(8'h04, 1'b1, 8'h06);
        bus_write(8'h05, 1'b1, 8'h40);
        bus_read(8'h05, 1'b1, 1'b1, got); check("thi_rd", {8'h00, got}, 16'h0040);
        bus_write(8'h00, 1'b1, 8'hC0);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("sq6_%0d", i), {15'd0, timer_out}, ((i % 6) < 3) ? 16'h0001 : 16'h0000);
            tick();
        end
        bus_write(8'h00, 1'b1, 8'h40);
        check("sq_stopped_out", {15'd0, timer_out}, 16'h0001);
        bus_read(8'h00, 1'b1, 1'b1, got); check("sq_status_tc", {8'h00, got}, 16'h0040);
        bus_read(8'h00, 1'b1, 1'b1, got); check("sq_status_clr", {8'h00, got}, 16'h0000);

        // Single pulse, L=4
        bus_write(8'h04, 1'b1, 8'h04);
        bus_write(8'h05, 1'b1, 8'h80);
        bus_write(8'h00, 1'b1, 8'hC0);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("pulse4_%0d", i), {15'd0, timer_out}, (i == 3) ? 16'h0000 : 16'h0001);
            tick();
        end
        bus_read(8'h00, 1'b1, 1'b1, got); check("pulse_status", {8'h00, got}, 16'h0040);
        bus_read(8'h00, 1'b1, 1'b1, got); check("pulse_status_clr", {8'h00, got}, 16'h0000);

        // Continuous pulse, stop after next TC
        bus_write(8'h05, 1'b1, 8'hC0);
        bus_write(8'h00, 1'b1, 8'hC0);
        bus_write(8'h00, 1'b1, 8'h80);
        lows = 0;
        for (int i = 0; i < 8; i++) begin
            if (timer_out == 1'b0) lows++;
            tick();
        end
        check("stop_tc_lows", 16'(lows), 16'h0001);
        bus_read(8'h00, 1'b1, 1'b1, got); check("stop_tc_status", {8'h00, got}, 16'h0040);

        // Continuous pulse, immediate stop before any TC
        bus_write(8'h00, 1'b1, 8'hC0);
        bus_write(8'h00, 1'b1, 8'h40);
        lows = 0;
        for (int i = 0; i < 8; i++) begin
            if (timer_out == 1'b0) lows++;
            tick();
        end
        check("stop_now_lows", 16'(lows), 16'h0000);
        bus_read(8'h00, 1'b1, 1'b1, got); check("stop_now_status", {8'h00, got}, 16'h0000);

        // Reset mid-count and mid-write
        bus_write(8'h04, 1'b1, 8'h06);
        bus_write(8'h05, 1'b1, 8'h40);
        bus_write(8'h00, 1'b1, 8'hC0);
        tick(); tick(); tick();
        check("pre_rst_low", {15'd0, timer_out}, 16'h0000);
        bus_addr(8'h3C, 1'b0, 1'b1);
        drv = 8'h99; drv_en = 1'b1; wr_n = 1'b0; rst = 1'b1;
        tick();
        check("mid_rst_timer_out", {15'd0, timer_out}, 16'h0001);
        drv_en = 1'b0;
        #1 check("mid_rst_float", {8'h00, ad}, 16'h00FF);
        rst = 1'b0; wr_n = 1'b1;
        bus_read(8'h3C, 1'b0, 1'b1, got); check("post_rst_mem3c", {8'h00, got}, 16'h0000);
        bus_read(8'hFF, 1'b0, 1'b1, got); check("post_rst_memff", {8'h00, got}, 16'h0000);
        bus_read(8'h00, 1'b1, 1'b1, got); check("post_rst_status", {8'h00, got}, 16'h0000);
        bus_read(8'h05, 1'b1, 1'b1, got); check("post_rst_thi", {8'h00, got}, 16'h0000);
        check("post_rst_out", {15'd0, timer_out}, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
